bp_resolve: RTL and testbench
=============================

Name: bp_resolve

Overview:
- Back end of the branch-prediction loop. Records each prediction issued by fetch in a small in-order queue.
- Checks every record against the actual control flow resolved in EX.
- Drives the corrective redirect and training pair {br_bus, delayslot_pc} back to the predictor and to fetch.
- Sits between the EX stage and the fetch and predictor logic; owns the flush decision on a misprediction.

Parameters:
- DEPTH, 4, number of outstanding prediction records; power of two, at least 2.
- BR_WD, 33, width of br_bus: {br_e, br_target[31:0]}.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- pred_valid  in  1  fetch pushes one record this cycle; only predicted-taken PCs are pushed.
- pred_pc  in  32  PC whose fetch carried the taken prediction.
- pred_target  in  32  predicted next PC.
- pred_ready  out  1  queue not full.
- res_valid  in  1  EX reports one instruction, in program order.
- res_pc  in  32  PC of the reported instruction.
- res_taken  in  1  res_pc is the delay slot of a taken branch.
- res_target  in  32  actual next PC when res_taken = 1.
- br_bus  out  BR_WD  {br_e, br_target}: redirect and predictor training.
- delayslot_pc  out  32  PC keyed by the redirect (training key).
- flush  out  1  kill younger fetched instructions.

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk.
  - Queue emptied; read and write pointers = 0; count = 0.
  - br_bus = 0, delayslot_pc = 0, flush = 0, pred_ready = 1.
  - A reset mid-operation discards all records and any pending redirect.
- Queue:
  - Circular FIFO of {pc, target}; pointers wrap modulo DEPTH.
  - pred_ready = (count != DEPTH), combinational.
  - A push happens when pred_valid & pred_ready. A push while full is ignored; fetch must hold.
- Match, combinational on res_valid:
  - hit = (count != 0) & (head.pc == res_pc).
  - On hit, pop the head. Predicted = taken, p_tgt = head.target.
  - On a miss, do not pop. Predicted = not-taken.
- Mispredict conditions, all evaluated in the res_valid cycle:
  - res_taken & !hit → redirect target = res_target.
  - res_taken & hit & (p_tgt != res_target) → redirect target = res_target.
  - !res_taken & hit → redirect target = res_pc + 4, modulo 2^32.
  - Otherwise correct; no redirect.
- Output timing:
  - br_bus, delayslot_pc and flush are registered.
  - They are valid exactly one cycle after the res_valid cycle.
  - br_e and flush pulse for one cycle; br_target = redirect target; delayslot_pc = res_pc.
  - With no mispredict, br_e = 0, flush = 0, and br_target and delayslot_pc hold their previous values.
- Flush on mispredict:
  - In the same edge that registers the redirect, the queue is cleared: count = 0, pointers = 0.
  - A push in the same cycle as a mispredicting resolve is dropped; flush wins.
- Simultaneous push and correct pop: both take effect; count unchanged.
- Resolve while empty: hit = 0. Treated as not-taken; redirects only if res_taken.
- Pipeline contract: res_valid must be low in the cycle after flush. EX is expected to be squashed; the block does not check this.

Optional Feature:
- Macro: BP_RESOLVE_STATS_EN.
- Defined:
  - Adds outputs stat_resolved[31:0] and stat_mispred[31:0].
  - stat_resolved increments on every res_valid & (hit | res_taken).
  - stat_mispred increments on every mispredict.
  - Both clear on reset, saturate at 32'hFFFF_FFFF, and update at the same edge as br_bus.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
- Push {0x1000, 0x2000}; resolve res_pc 0x1000, taken, target 0x2000.
  - Required: br_e stays 0 and flush stays 0.
  - Queue is empty afterwards.
- Push {0x1000, 0x2000}; resolve 0x1000, taken, target 0x3000.
  - Next cycle: br_bus = {1, 0x3000}, delayslot_pc = 0x1000, flush = 1 for one cycle.
- Push {0x1000, 0x2000}; resolve 0x1000, not taken.
  - Required: br_bus = {1, 0x1004}; queue is cleared.
- Empty queue; resolve 0x0500, taken, target 0x0800.
  - Required: br_bus = {1, 0x0800}, delayslot_pc = 0x0500.
- Fill with DEPTH = 4 pushes.
  - Required: pred_ready = 0 and a fifth push is ignored.
  - Resolving the 4 records correctly in order pops them FIFO, and pred_ready = 1 after the first pop.
- Boundary cases:
  - Assert resetn = 0 with 3 records queued; required: count = 0, br_bus = 0.
  - Resolve 0xFFFF_FFFC, not taken, with a matching head record; required: br_target = 0x0000_0000.

Source files
------------

// File: rtl/bp_resolve.sv
// bp_resolve: in-order queue of issued taken-predictions, checked against EX resolution.
// Optional build macro BP_RESOLVE_STATS_EN adds resolved/mispredict counters.
module bp_resolve #(
  parameter int DEPTH = 4,
  parameter int BR_WD = 33
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  input  logic [31:0]      pred_target,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic [BR_WD-1:0] br_bus,
  output logic [31:0]      delayslot_pc,
  output logic             flush
`ifdef BP_RESOLVE_STATS_EN
  ,
  output logic [31:0]      stat_resolved,
  output logic [31:0]      stat_mispred
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   pc_q  [DEPTH];
  logic [31:0]   tgt_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          br_e_q;
  logic [31:0]   br_target_q, br_target_d;
  logic [31:0]   dslot_q, dslot_d;
  logic          flush_q;

  logic [31:0]   head_pc, head_tgt;
  logic          not_empty, hit, push, pop, mispredict;
  logic [31:0]   redirect_tgt;

  assign head_pc   = pc_q[rd_ptr_q];
  assign head_tgt  = tgt_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign hit       = res_valid & not_empty & (head_pc == res_pc);

  // A hit that resolves not-taken, a taken branch with no record, or a wrong
  // predicted target all require a redirect.
  always_comb begin
    mispredict   = 1'b0;
    redirect_tgt = res_target;
    if (res_valid) begin
      if (res_taken) begin
        mispredict = !hit || (head_tgt != res_target);
      end else if (hit) begin
        mispredict   = 1'b1;
        redirect_tgt = res_pc + 32'd4;
      end
    end
  end

  assign pred_ready = (count_q != FULL_CNT);
  assign push       = pred_valid & pred_ready & !mispredict;
  assign pop        = hit & !mispredict;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mispredict) begin
      // The flush empties the queue and drops any same-cycle push.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    br_target_d = br_target_q;
    dslot_d     = dslot_q;
    if (mispredict) begin
      br_target_d = redirect_tgt;
      dslot_d     = res_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q]  <= pred_pc;
      tgt_q[wr_ptr_q] <= pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      br_e_q      <= 1'b0;
      br_target_q <= '0;
      dslot_q     <= '0;
      flush_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      br_e_q      <= mispredict;
      br_target_q <= br_target_d;
      dslot_q     <= dslot_d;
      flush_q     <= mispredict;
    end
  end

  assign br_bus       = BR_WD'({br_e_q, br_target_q});
  assign delayslot_pc = dslot_q;
  assign flush        = flush_q;

`ifdef BP_RESOLVE_STATS_EN
  logic [31:0] stat_res_q, stat_res_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_res_d = stat_res_q;
    stat_mis_d = stat_mis_q;
    if (res_valid && (hit || res_taken) && (stat_res_q != 32'hFFFF_FFFF))
      stat_res_d = stat_res_q + 32'd1;
    if (mispredict && (stat_mis_q != 32'hFFFF_FFFF))
      stat_mis_d = stat_mis_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_resolved = stat_res_q;
  assign stat_mispred  = stat_mis_q;
`endif

endmodule

// File: tb/tb_bp_resolve.sv
// Directed bench for bp_resolve: hand-computed redirect/flush/ready expectations.
module tb_bp_resolve;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pred_valid;
  logic [31:0] pred_pc, pred_target;
  logic        pred_ready;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic [32:0] br_bus;
  logic [31:0] delayslot_pc;
  logic        flush;
`ifdef BP_RESOLVE_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bp_resolve #(.DEPTH(4), .BR_WD(33)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pred_valid   (pred_valid),
    .pred_pc      (pred_pc),
    .pred_target  (pred_target),
    .pred_ready   (pred_ready),
    .res_valid    (res_valid),
    .res_pc       (res_pc),
    .res_taken    (res_taken),
    .res_target   (res_target),
    .br_bus       (br_bus),
    .delayslot_pc (delayslot_pc),
    .flush        (flush)
`ifdef BP_RESOLVE_STATS_EN
    ,
    .stat_resolved(stat_resolved),
    .stat_mispred (stat_mispred)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] tgt);
    pred_valid = 1'b1; pred_pc = pc; pred_target = tgt;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    res_valid = 1'b1; res_pc = pc; res_taken = tk; res_target = tgt;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; pred_valid = 1'b0; pred_pc = '0; pred_target = '0;
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    tick(); tick();
    check("rst_br_bus", 64'(br_bus), 64'h0);
    check("rst_dslot", 64'(delayslot_pc), 64'h0);
    check("rst_flush", 64'(flush), 64'h0);
    check("rst_ready", 64'(pred_ready), 64'h1);
    resetn = 1'b1;
    tick();

    // Correct prediction: no redirect, record consumed
    push(32'h1000, 32'h2000);
    resolve(32'h1000, 1'b1, 32'h2000);
    check("ok_br_e", 64'(br_bus[32]), 64'h0);
    check("ok_flush", 64'(flush), 64'h0);
    resolve(32'h1000, 1'b1, 32'h2000);
    check("ok_empty_bus", 64'(br_bus), {31'h0, 1'b1, 32'h2000});
    tick();
    check("flush_pulse", 64'(flush), 64'h0);

    // Wrong target
    push(32'h1000, 32'h2000);
    resolve(32'h1000, 1'b1, 32'h3000);
    check("tgt_bus", 64'(br_bus), {31'h0, 1'b1, 32'h3000});
    check("tgt_dslot", 64'(delayslot_pc), 64'h1000);
    check("tgt_flush", 64'(flush), 64'h1);
    tick();
    check("tgt_hold_bus", 64'(br_bus), {31'h0, 1'b0, 32'h3000});
    check("tgt_hold_dslot", 64'(delayslot_pc), 64'h1000);
    check("tgt_flush_off", 64'(flush), 64'h0);

    // Predicted taken, actually not taken; second record must be cleared
    push(32'h1000, 32'h2000);
    push(32'h1010, 32'h2010);
    resolve(32'h1000, 1'b0, 32'h0);
    check("nt_bus", 64'(br_bus), {31'h0, 1'b1, 32'h1004});
    check("nt_flush", 64'(flush), 64'h1);
    tick();
    resolve(32'h1010, 1'b0, 32'h0);
    check("nt_cleared", 64'(br_bus), {31'h0, 1'b0, 32'h1004});

    // Taken with empty queue
    resolve(32'h0500, 1'b1, 32'h0800);
    check("empty_bus", 64'(br_bus), {31'h0, 1'b1, 32'h0800});
    check("empty_dslot", 64'(delayslot_pc), 64'h0500);
    tick();

    // Push in the same cycle as a mispredicting resolve is dropped
    push(32'h1000, 32'h2000);
    pred_valid = 1'b1; pred_pc = 32'h7000; pred_target = 32'h7100;
    resolve(32'h1000, 1'b1, 32'h3000);
    pred_valid = 1'b0;
    check("drop_bus", 64'(br_bus), {31'h0, 1'b1, 32'h3000});
    tick();
    resolve(32'h7000, 1'b1, 32'h7100);
    check("drop_push", 64'(br_bus), {31'h0, 1'b1, 32'h7100});
    tick();

    // Fill, overflow attempt, FIFO drain with a simultaneous push/pop
    for (int i = 0; i < 4; i++) push(32'h4000 + 32'(i) * 32'h10, 32'h8000 + 32'(i) * 32'h10);
    check("full_ready", 64'(pred_ready), 64'h0);
    push(32'h9000, 32'h9100);
    check("full_ready2", 64'(pred_ready), 64'h0);
    resolve(32'h4000, 1'b1, 32'h8000);
    check("pop0_br_e", 64'(br_bus[32]), 64'h0);
    check("pop0_ready", 64'(pred_ready), 64'h1);
    pred_valid = 1'b1; pred_pc = 32'h5000; pred_target = 32'h6000;
    resolve(32'h4010, 1'b1, 32'h8010);
    pred_valid = 1'b0;
    check("pushpop_br_e", 64'(br_bus[32]), 64'h0);
    check("pushpop_ready", 64'(pred_ready), 64'h1);
    resolve(32'h4020, 1'b1, 32'h8020);
    check("pop2_br_e", 64'(br_bus[32]), 64'h0);
    resolve(32'h4030, 1'b1, 32'h8030);
    check("pop3_br_e", 64'(br_bus[32]), 64'h0);
    resolve(32'h5000, 1'b1, 32'h6000);
    check("pop4_br_e", 64'(br_bus[32]), 64'h0);
    resolve(32'h9000, 1'b1, 32'h9100);
    check("ovf_ignored", 64'(br_bus), {31'h0, 1'b1, 32'h9100});
    tick();

    // Reset with records queued and a would-be redirect in flight
    push(32'hA000, 32'hB000);
    push(32'hA010, 32'hB010);
    push(32'hA020, 32'hB020);
    resetn = 1'b0;
    resolve(32'hC000, 1'b1, 32'hD000);
    check("mrst_bus", 64'(br_bus), 64'h0);
    check("mrst_flush", 64'(flush), 64'h0);
    check("mrst_ready", 64'(pred_ready), 64'h1);
    resetn = 1'b1;
    tick();
    resolve(32'hA000, 1'b1, 32'hB000);
    check("mrst_empty", 64'(br_bus), {31'h0, 1'b1, 32'hB000});
    tick();

    // PC+4 wraps modulo 2^32
    push(32'hFFFF_FFFC, 32'h1234);
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
    check("wrap_bus", 64'(br_bus), {31'h0, 1'b1, 32'h0});
    check("wrap_dslot", 64'(delayslot_pc), 64'hFFFF_FFFC);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
